// File: rtl/slap_arb_pkg.sv
// slap_arb_pkg: shared constants and helpers for the slap round-robin arbiter.
//   src_w()        width of a requester index (at least 1 bit)
//   n_req_legal()  true when a requester count is in the supported range
//   OUT_*_RST      reset values of the registered output beat
package slap_arb_pkg;

  localparam int N_REQ_MIN = 32'sd2;
  localparam int N_REQ_MAX = 32'sd16;

  localparam int unsigned OUT_DATA_RST = 32'd0;
  localparam int unsigned OUT_SRC_RST  = 32'd0;

  // Ceiling log2 with a floor of one bit so N_REQ=2 still gets a real index.
  function automatic int src_w(input int n);
    int w;
    w = 32'sd1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 32'sd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic bit n_req_legal(input int n);
    return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
  endfunction

endpackage

// File: rtl/slap_rr_arbiter_if.sv
// slap_rr_arbiter_if: requester-side and downstream handshake bundle.
//   req_valid/req_data/req_ready  N_REQ valid/ready requester beats
//   req_last                      burst terminator (only with SLAP_ARB_LOCK_EN)
//   out_valid/out_data/out_src    registered output beat and its source index
//   out_ready                     downstream accept
// Modport master is the arbiter's view; slave is the surrounding logic's view.
interface slap_rr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  import slap_arb_pkg::*;

  localparam int SRC_W = src_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;

`ifdef SLAP_ARB_LOCK_EN
  logic [N_REQ-1:0]        req_last;

  modport master (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport slave (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
`else
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
`endif

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req        request vector
//   ptr        highest-priority index; search ascends from here and wraps
//   gnt        one-hot grant (zero when nothing requests)
//   idx        encoded grant index
//   any_valid  at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [SRC_W-1:0] idx,
  output logic             any_valid
);

  // Walk N_REQ positions from ptr with a modulo wrap; first hit wins.
  always_comb begin
    int pos_s;
    gnt       = '0;
    idx       = '0;
    any_valid = 1'b0;
    pos_s     = 32'sd0;
    for (int i = 0; i < N_REQ; i++) begin
      pos_s = int'(ptr) + i;
      if (pos_s >= N_REQ) begin
        pos_s = pos_s - N_REQ;
      end else begin
        pos_s = pos_s;
      end
      if (!any_valid && req[pos_s]) begin
        any_valid  = 1'b1;
        idx        = SRC_W'(pos_s);
        gnt[pos_s] = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/slap_rr_arbiter.sv
// slap_rr_arbiter: round-robin arbiter feeding one registered output stage.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       slap_rr_arbiter_if.master (requester beats in, one beat out)
// One beat per cycle, one clock of latency. Optional macro SLAP_ARB_LOCK_EN
// adds req_last and keeps a requester granted until its burst ends.
module slap_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  slap_rr_arbiter_if.master bus
);
  import slap_arb_pkg::*;

  localparam int SRC_W  = src_w(N_REQ);
  // An out-of-range N_REQ yields an arbiter that never accepts anything.
  localparam bit CFG_OK = n_req_legal(N_REQ);

  logic                 out_valid_r;
  logic [DATA_W-1:0]    out_data_r;
  logic [SRC_W-1:0]     out_src_r;
  logic [SRC_W-1:0]     ptr_r;
  logic [SRC_W-1:0]     ptr_inc_s;
  logic [SRC_W-1:0]     ptr_next_s;
  logic [N_REQ-1:0]     req_elig_s;
  logic [N_REQ-1:0]     gnt_s;
  logic [SRC_W-1:0]     idx_s;
  logic                 any_s;
  logic                 load_s;

  // The output register can take a new beat when empty or draining this cycle.
  assign load_s = CFG_OK && (!out_valid_r || bus.out_ready);

  rr_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req       (req_elig_s),
    .ptr       (ptr_r),
    .gnt       (gnt_s),
    .idx       (idx_s),
    .any_valid (any_s)
  );

  // Successor of the granted index, wrapping at N_REQ-1 (not at a power of two).
  always_comb begin
    if (idx_s == SRC_W'(N_REQ - 1)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = idx_s + SRC_W'(1);
    end
  end

`ifdef SLAP_ARB_LOCK_EN
  logic             lock_r;
  logic [SRC_W-1:0] lock_id_r;

  // While a burst is open only its owner is eligible.
  always_comb begin
    req_elig_s = bus.req_valid;
    if (lock_r) begin
      req_elig_s            = '0;
      req_elig_s[lock_id_r] = bus.req_valid[lock_id_r];
    end else begin
      req_elig_s = bus.req_valid;
    end
  end

  // Pointer moves only when a burst closes, landing just past its owner.
  assign ptr_next_s = bus.req_last[idx_s] ? ptr_inc_s : ptr_r;

  // Burst lock: opened by a non-last beat, closed by a last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r    <= 1'b0;
      lock_id_r <= '0;
    end else if (load_s && any_s) begin
      if (bus.req_last[idx_s]) begin
        lock_r <= 1'b0;
      end else begin
        lock_r    <= 1'b1;
        lock_id_r <= idx_s;
      end
    end else begin
      lock_r <= lock_r;
    end
  end
`else
  assign req_elig_s = bus.req_valid;
  assign ptr_next_s = ptr_inc_s;
`endif

  // Ready is the grant qualified by load; forced low while in reset.
  assign bus.req_ready = (load_s && !rst) ? gnt_s : '0;

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_W'(OUT_DATA_RST);
      out_src_r   <= SRC_W'(OUT_SRC_RST);
      ptr_r       <= '0;
    end else if (load_s) begin
      if (any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.req_data[int'(idx_s)*DATA_W +: DATA_W];
        out_src_r   <= idx_s;
        ptr_r       <= ptr_next_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;

endmodule

// File: tb/tb_slap_rr_arbiter.sv
// tb_slap_rr_arbiter: directed scenarios followed by randomized traffic, all
// checked every cycle against a distance-based round-robin reference model.
module tb_slap_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] last_v;

  slap_rr_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

`ifdef SLAP_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
  assign bus.req_last = last_v;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  slap_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int           m_ptr     = 0;
  bit           m_ov      = 1'b0;
  logic [W-1:0] m_od      = '0;
  int           m_os      = 0;
  bit           m_lock    = 1'b0;
  int           m_lock_id = 0;
  int           m_acc     = -1;

  // Randomized requester state.
  logic [N-1:0]   pend_v;
  logic [N*W-1:0] pend_d;
  logic [N-1:0]   pend_l;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Valid requester with the smallest forward distance from p wins.
  function automatic int pick(input logic [N-1:0] v, input int p);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d = (i - p + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // Check current cycle against the model, advance the model, cross the edge.
  task automatic tick();
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    int g;
    bit load;
    @(negedge clk);
    elig = bus.req_valid;
    if (m_lock) begin
      elig            = '0;
      elig[m_lock_id] = bus.req_valid[m_lock_id];
    end
    g    = pick(elig, m_ptr);
    load = !m_ov || bus.out_ready;
    exp_rdy = '0;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_eq("out_data",  32'(bus.out_data),  32'(m_od));
    check_eq("out_src",   32'(bus.out_src),   32'(m_os));
    m_acc = -1;
    if (rst) begin
      m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = 0; m_lock = 1'b0; m_lock_id = 0;
    end else if (load) begin
      if (g >= 0) begin
        m_acc = g;
        m_ov  = 1'b1;
        m_od  = bus.req_data[g*W +: W];
        m_os  = g;
        if (LOCK_EN && !last_v[g]) begin
          m_lock    = 1'b1;
          m_lock_id = g;
        end else begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % N;
        end
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_a0();
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 8'(8'hA0 + i);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    last_v = '1;
    pend_v = '0; pend_d = '0; pend_l = '1;
    @(posedge clk);
    #1;

    // Reset with every requester asking.
    bus.req_valid = 4'b1111;
    set_data_a0();
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_src",   32'(bus.out_src),   32'd0);
    end

    // Round-robin over all four: 0,1,2,3,0.
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("rr_src",  32'(bus.out_src),  32'(c % N));
      check_eq("rr_data", 32'(bus.out_data), 32'(8'hA0 + (c % N)));
    end

    // Backpressure holding a beat from requester 2.
    tick();
    tick();
    check_eq("bp_src_pre", 32'(bus.out_src), 32'd2);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("bp_src_hold",  32'(bus.out_src),  32'd2);
      check_eq("bp_data_hold", 32'(bus.out_data), 32'hA2);
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("bp_next_src", 32'(bus.out_src), 32'd3);

    // Sparse requests and wrap-around.
    bus.req_valid = 4'b0100;
    tick();
    check_eq("sp_src2", 32'(bus.out_src), 32'd2);
    bus.req_valid = 4'b0010;
    tick();
    check_eq("sp_src1", 32'(bus.out_src), 32'd1);
    bus.req_valid = 4'b0001;
    tick();
    check_eq("sp_wrap0", 32'(bus.out_src), 32'd0);

    // Reset while a beat is stalled at the output.
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_eq("mid_rst_src", 32'(bus.out_src), 32'd0);

`ifdef SLAP_ARB_LOCK_EN
    // Three-beat burst from requester 1 while requester 2 waits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    last_v = 4'b1101;
    for (int b = 0; b < 3; b++) begin
      bus.req_data[1*W +: W] = 8'(8'h10 + b);
      if (b == 2) last_v = 4'b1111;
      tick();
      check_eq("lock_src", 32'(bus.out_src), 32'd1);
    end
    bus.req_valid = 4'b0100;
    tick();
    check_eq("lock_after", 32'(bus.out_src), 32'd2);
`endif

    // Randomized traffic with occasional resets.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          pend_v[i]        = 1'b1;
          pend_d[i*W +: W] = 8'($urandom);
          pend_l[i]        = ($urandom_range(0, 2) != 0);
        end
      end
      bus.req_valid = pend_v;
      bus.req_data  = pend_d;
      last_v        = pend_l;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 60) == 0);
      tick();
      if (m_acc >= 0) pend_v[m_acc] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
